// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: glyph constants,
// scan FSM states and the staged display configuration record.
package seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_e;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  neg;
        logic [3:0]  blank;
        logic [3:0]  blink;
    } disp_cfg_t;

    // Active-low anode pattern selecting a single digit.
    function automatic logic [3:0] anode_sel_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Active-low hex-to-seven-segment decoder (a..g on bits 0..6) with a
// minus-sign override.
module hex7seg
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] n_i,
    input  logic       negative_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        if (negative_i) begin
            seg_o = SEG_MINUS;
        end else begin
            unique case (n_i)
                4'h0: seg_o = 7'b1000000;
                4'h1: seg_o = 7'b1111001;
                4'h2: seg_o = 7'b0100100;
                4'h3: seg_o = 7'b0110000;
                4'h4: seg_o = 7'b0011001;
                4'h5: seg_o = 7'b0010010;
                4'h6: seg_o = 7'b0000010;
                4'h7: seg_o = 7'b1111000;
                4'h8: seg_o = 7'b0000000;
                4'h9: seg_o = 7'b0010000;
                4'hA: seg_o = 7'b0001000;
                4'hB: seg_o = 7'b0000011;
                4'hC: seg_o = 7'b1000110;
                4'hD: seg_o = 7'b0100001;
                4'hE: seg_o = 7'b0000110;
                4'hF: seg_o = 7'b0001110;
                default: seg_o = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller: frame-synchronous shadow latch,
// guarded BLANK/DRIVE slot sequencing, blink and leading-zero suppression.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  neg_mask,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  blink_mask,
    input  logic        lz_en,
    input  logic        update,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST       = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST     = FW'(BLINK_DIV - 1);
    localparam logic [1:0]    DIGIT_LAST     = 2'(NUM_DIGITS - 1);

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_off_q, blink_off_d;
    disp_cfg_t     stage_q, stage_d;
    disp_cfg_t     shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          fd_q, fd_d;

    logic          slot_wrap;
    logic          frame_wrap;
    logic          enter_drive;
    logic [3:0]    lz_dark;
    logic          digit_dark;
    logic [3:0]    cur_nibble;
    logic [6:0]    dec_seg;

    assign slot_wrap   = (cnt_q == CNT_LAST);
    assign frame_wrap  = slot_wrap && (digit_q == DIGIT_LAST);
    assign enter_drive = (state_q == BLANK) && (cnt_q == CNT_BLANK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            digit_q     <= '0;
            frame_q     <= '0;
            blink_off_q <= 1'b0;
            stage_q     <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            frame_q     <= frame_d;
            blink_off_q <= blink_off_d;
            stage_q     <= stage_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            fd_q        <= fd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = slot_wrap ? '0 : cnt_q + CW'(1);
        digit_d     = slot_wrap ? digit_q + 2'd1 : digit_q;
        frame_d     = frame_q;
        blink_off_d = blink_off_q;
        stage_d     = stage_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        fd_d        = frame_wrap;

        unique case (state_q)
            BLANK:   if (enter_drive) state_d = DRIVE;
            DRIVE:   if (slot_wrap)   state_d = BLANK;
            default: state_d = BLANK;
        endcase

        if (update) begin
            stage_d   = '{value: value, neg: neg_mask, blank: blank_mask, blink: blink_mask};
            pending_d = 1'b1;
        end

        // Commit uses the pre-edge staging value, so an update landing on the
        // wrap edge stays pending for the following frame.
        if (frame_wrap) begin
            if (pending_q) shadow_d = stage_q;
            pending_d = update;
            if (frame_q == FRAME_LAST) begin
                frame_d     = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end

    always_comb begin
        logic upper_zero;
        int unsigned j;
        lz_dark    = '0;
        upper_zero = 1'b1;
        j          = 0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            j          = NUM_DIGITS - 1 - k;
            upper_zero = upper_zero && (shadow_q.value[j*4 +: 4] == 4'h0) && !shadow_q.neg[j];
            if (j != 0) lz_dark[j] = lz_en && upper_zero;
        end
    end

    assign cur_nibble = shadow_q.value[digit_q*4 +: 4];
    assign digit_dark = shadow_q.blank[digit_q]
                     || (shadow_q.blink[digit_q] && blink_off_q)
                     || lz_dark[digit_q];

    hex7seg u_hex7seg (
        .n_i        (cur_nibble),
        .negative_i (shadow_q.neg[digit_q]),
        .seg_o      (dec_seg)
    );

    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (enter_drive) begin
            an_d  = anode_sel_n(digit_q);
            seg_d = digit_dark ? SEG_OFF : dec_seg;
        end else if (state_d == BLANK) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: per-frame expected glyphs are queued by
// each scenario and compared cycle by cycle against the scanned pins.
module tb_seg_scan_ctrl;

    localparam int P = 8;
    localparam int B = 2;
    localparam int D = 2;
    localparam logic [6:0] OFF = 7'h7F;
    localparam logic [6:0] MIN = 7'h3F;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  neg_mask, blank_mask, blink_mask;
    logic        lz_en, update;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B), .BLINK_DIV(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .neg_mask   (neg_mask),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .lz_en      (lz_en),
        .update     (update),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    typedef struct {
        int          cyc;
        logic [15:0] val;
        logic [3:0]  neg;
        logic [3:0]  blank;
        logic [3:0]  blink;
    } upd_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] exp_q[$];
    upd_t       sched_q[$];
    bit         first_frame;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic push_frame(input logic [6:0] s0, s1, s2, s3);
        exp_q.push_back(s0);
        exp_q.push_back(s1);
        exp_q.push_back(s2);
        exp_q.push_back(s3);
    endtask

    task automatic sched(input int cyc, input logic [15:0] v, input logic [3:0] ng, bl, bk);
        upd_t u;
        u.cyc = cyc; u.val = v; u.neg = ng; u.blank = bl; u.blink = bk;
        sched_q.push_back(u);
    endtask

    // Runs ncyc cycles of one frame, checking pins against the queued glyphs.
    task automatic run_frame(input int ncyc, input string tag);
        logic [6:0] e[4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fd;
        int         s, k;
        upd_t       u;
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL %s scoreboard: got empty queue, want 4 entries", tag);
                e[i] = OFF;
            end else begin
                e[i] = exp_q.pop_front();
            end
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            update = 1'b0;
            s = c / P;
            k = c % P;
            exp_an  = (k < B) ? 4'hF : ~(4'b0001 << s);
            exp_seg = (k < B) ? OFF : e[s];
            exp_fd  = (c == 0) && !first_frame;
            n_cmp++;
            if (an !== exp_an) begin
                n_bad++; $display("FAIL %s an c=%0d got %b want %b", tag, c, an, exp_an);
            end
            n_cmp++;
            if (seg !== exp_seg) begin
                n_bad++; $display("FAIL %s seg c=%0d got %b want %b", tag, c, seg, exp_seg);
            end
            n_cmp++;
            if (dp !== 1'b1) begin
                n_bad++; $display("FAIL %s dp c=%0d got %b want 1", tag, c, dp);
            end
            n_cmp++;
            if (frame_done !== exp_fd) begin
                n_bad++; $display("FAIL %s frame_done c=%0d got %b want %b", tag, c, frame_done, exp_fd);
            end
            if (sched_q.size() > 0 && sched_q[0].cyc == c) begin
                u          = sched_q.pop_front();
                value      = u.val;
                neg_mask   = u.neg;
                blank_mask = u.blank;
                blink_mask = u.blink;
                update     = 1'b1;
            end
        end
        first_frame = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        update = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        first_frame = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (an !== 4'hF) begin n_bad++; $display("FAIL reset an got %b want 1111", an); end
            n_cmp++;
            if (seg !== OFF) begin n_bad++; $display("FAIL reset seg got %b want 1111111", seg); end
            n_cmp++;
            if (dp !== 1'b1) begin n_bad++; $display("FAIL reset dp got %b want 1", dp); end
            n_cmp++;
            if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset frame_done got %b want 0", frame_done); end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        first_frame = 1'b1;
    endtask

    task automatic test_basic_scan();
        sched(5, 16'h1234, 4'h0, 4'h0, 4'h0);
        push_frame(glyph(0), glyph(0), glyph(0), glyph(0));
        run_frame(32, "basic_f0");
        push_frame(glyph(4), glyph(3), glyph(2), glyph(1));
        run_frame(32, "basic_f1");
        push_frame(glyph(4), glyph(3), glyph(2), glyph(1));
        run_frame(32, "basic_f2");
    endtask

    task automatic test_midframe_update();
        sched(10, 16'h00A5, 4'h0, 4'h0, 4'h0);
        push_frame(glyph(4), glyph(3), glyph(2), glyph(1));
        run_frame(32, "mid_hold");
        push_frame(glyph(5), glyph(4'hA), glyph(0), glyph(0));
        run_frame(32, "mid_commit");
    endtask

    task automatic test_lz_neg();
        lz_en = 1'b1;
        sched(4, 16'h0005, 4'b0010, 4'h0, 4'h0);
        push_frame(glyph(5), glyph(4'hA), OFF, OFF);
        run_frame(32, "lz_a5");
        sched(20, 16'h0000, 4'h0, 4'h0, 4'h0);
        push_frame(glyph(5), MIN, OFF, OFF);
        run_frame(32, "lz_minus");
        push_frame(glyph(0), OFF, OFF, OFF);
        run_frame(32, "lz_zero");
        lz_en = 1'b0;
    endtask

    task automatic test_blink();
        do_reset();
        sched(5, 16'h0008, 4'h0, 4'h0, 4'b0001);
        push_frame(glyph(0), glyph(0), glyph(0), glyph(0));
        run_frame(32, "blink_f0");
        push_frame(glyph(8), glyph(0), glyph(0), glyph(0));
        run_frame(32, "blink_f1");
        push_frame(OFF, glyph(0), glyph(0), glyph(0));
        run_frame(32, "blink_f2");
        push_frame(OFF, glyph(0), glyph(0), glyph(0));
        run_frame(32, "blink_f3");
        push_frame(glyph(8), glyph(0), glyph(0), glyph(0));
        run_frame(32, "blink_f4");
        sched(9, 16'h0008, 4'h0, 4'b0100, 4'b0001);
        push_frame(glyph(8), glyph(0), glyph(0), glyph(0));
        run_frame(32, "blink_f5");
        push_frame(OFF, glyph(0), OFF, glyph(0));
        run_frame(32, "blink_f6_blank");
    endtask

    task automatic test_back_to_back();
        do_reset();
        sched(3, 16'h1111, 4'h0, 4'h0, 4'h0);
        sched(12, 16'h2222, 4'h0, 4'h0, 4'h0);
        sched(31, 16'h3333, 4'h0, 4'h0, 4'h0);
        push_frame(glyph(0), glyph(0), glyph(0), glyph(0));
        run_frame(32, "b2b_n");
        push_frame(glyph(2), glyph(2), glyph(2), glyph(2));
        run_frame(32, "b2b_n1");
        push_frame(glyph(3), glyph(3), glyph(3), glyph(3));
        run_frame(32, "b2b_n2");
        push_frame(glyph(3), glyph(3), glyph(3), glyph(3));
        run_frame(32, "b2b_n3");
    endtask

    task automatic test_reset_mid();
        do_reset();
        sched(3, 16'h1234, 4'h0, 4'h0, 4'h0);
        push_frame(glyph(0), glyph(0), glyph(0), glyph(0));
        run_frame(32, "rmid_f0");
        sched(3, 16'hBEEF, 4'h0, 4'h0, 4'h0);
        push_frame(glyph(4), glyph(3), glyph(2), glyph(1));
        run_frame(22, "rmid_part");
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (an !== 4'hF) begin n_bad++; $display("FAIL rmid_edge an got %b want 1111", an); end
        n_cmp++;
        if (seg !== OFF) begin n_bad++; $display("FAIL rmid_edge seg got %b want 1111111", seg); end
        rst = 1'b0;
        first_frame = 1'b1;
        push_frame(glyph(0), glyph(0), glyph(0), glyph(0));
        run_frame(32, "rmid_after0");
        push_frame(glyph(0), glyph(0), glyph(0), glyph(0));
        run_frame(32, "rmid_after1");
    endtask

    initial begin
        rst        = 1'b1;
        value      = '0;
        neg_mask   = '0;
        blank_mask = '0;
        blink_mask = '0;
        lz_en      = 1'b0;
        update     = 1'b0;
        test_reset();
        test_basic_scan();
        test_midframe_update();
        test_lz_neg();
        test_blink();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
